// File: rtl/acq_status_pio.sv
// acq_status_pio: Avalon-MM input PIO for acquisition status lines.
// Synchronises an asynchronous status bus, captures selected edges into a
// sticky register with a maskable level interrupt, and keeps a saturating
// count of bit-0 events for software polling.
module acq_status_pio #(
    parameter int DATA_WIDTH = 8,   // status bus width (1..32)
    parameter int EDGE_TYPE  = 0,   // 0 = rising, 1 = falling, 2 = any edge
    parameter int CNT_WIDTH  = 16   // bit-0 event counter width (1..32)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_EVCNT   = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_ONE;
    endfunction

    // Synchroniser chain: s1/s2 resolve metastability, s3 is the previous s2.
    logic [DATA_WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [1:0]            arm_q, arm_d;
    logic                  armed;

    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_det;

    logic [CNT_WIDTH-1:0]  evcnt_q, evcnt_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_field;
    logic                  wd_unused;

    assign wr_en     = chipselect & ~write_n;
    assign wr_field  = writedata[DATA_WIDTH-1:0];
    // Upper write-data bits have no register behind them.
    assign wd_unused = ^writedata;

    // Arm counter runs 0..3 after reset so reset-valued synchroniser flops
    // cannot be mistaken for real transitions.
    always_comb begin
        arm_d = arm_q;
        if (arm_q != 2'd3) begin
            arm_d = arm_q + 2'd1;
        end
    end

    assign armed = (arm_q == 2'd3);

    // Per-bit edge selection from the synchronised value and its history.
    always_comb begin
        edge_raw = s2_q & ~s3_q;
        if (EDGE_TYPE == 1) begin
            edge_raw = ~s2_q & s3_q;
        end else if (EDGE_TYPE == 2) begin
            edge_raw = s2_q ^ s3_q;
        end
    end

    assign edge_det = armed ? edge_raw : '0;

    // Register next-state: write-clear beats a bit-0 event on the counter,
    // while a new edge beats a same-cycle write-1-to-clear on EDGECAP.
    always_comb begin
        evcnt_d   = evcnt_q;
        mask_d    = mask_q;
        edgecap_d = edgecap_q;

        if (wr_en && (address == ADDR_EVCNT)) begin
            evcnt_d = '0;
        end else if (edge_det[0]) begin
            evcnt_d = sat_inc(evcnt_q);
        end

        if (wr_en && (address == ADDR_IRQMASK)) begin
            mask_d = wr_field;
        end

        if (wr_en && (address == ADDR_EDGECAP)) begin
            edgecap_d = edgecap_q & ~wr_field;
        end
        edgecap_d = edgecap_d | edge_det;
    end

    // Read mux sees register state before this cycle's update.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d = 32'(s2_q);
            ADDR_EVCNT:   readdata_d = 32'(evcnt_q);
            ADDR_IRQMASK: readdata_d = 32'(mask_q);
            ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
            default:      readdata_d = '0;
        endcase
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            arm_q      <= '0;
            evcnt_q    <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            arm_q      <= arm_d;
            evcnt_q    <= evcnt_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & mask_q);

endmodule
